multicycle_cpu: RTL

//  Parametrised multi-cycle MIPS-subset core; successor to the single-cycle CPU top.

---
 rtl/multicycle_cpu.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: multi-cycle MIPS-subset core with a single shared req/ack memory port.
// Instruction fetch and data access share the port, so one slow RAM can serve both.
// Optional build macro MCPU_PERF_EN adds the cycle_cnt / instret_cnt performance counters.
module multicycle_cpu #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              RST,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out
`ifdef MCPU_PERF_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instret_cnt
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SLL = 6'b000000;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir;
    logic [31:0]       reg_a;
    logic [31:0]       reg_b;
    logic [31:0]       mdr;
    logic [31:0]       regfile [32];

    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        func;
    logic [15:0]       imm16;
    logic [25:0]       imm26;

    logic [31:0]       sext_imm;
    logic [31:0]       zext_imm;
    logic [31:0]       alu_result;
    logic              r_known;
    logic              is_alu;
    logic              is_mem;
    logic              is_jump;
    logic              branch_taken;
    logic [4:0]        dst;
    logic [31:0]       wb_data;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] mem_target;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign func  = ir[5:0];
    assign imm16 = ir[15:0];
    assign imm26 = ir[25:0];

    assign pc_out        = pc;
    assign pc_plus4      = pc + ADDR_W'(4);
    assign branch_target = pc + ADDR_W'({sext_imm[29:0], 2'b00});
    assign jump_target   = (pc & ~ADDR_W'(32'h0FFF_FFFF)) | ADDR_W'({imm26, 2'b00});
    assign mem_target    = ADDR_W'({alu_result[31:2], 2'b00});

    assign is_alu       = r_known || (op == OP_ADDI) || (op == OP_ORI);
    assign is_mem       = (op == OP_LW) || (op == OP_SW);
    assign is_jump      = (op == OP_J);
    assign branch_taken = ((op == OP_BEQ) && (reg_a == reg_b)) ||
                          ((op == OP_BNE) && (reg_a != reg_b));
    assign dst          = (op == OP_RTYPE) ? rd : rt;
    assign wb_data      = (op == OP_LW) ? mdr : alu_result;

    // ALU and instruction classification from the latched operands and IR
    always_comb begin
        sext_imm   = {{16{imm16[15]}}, imm16};
        zext_imm   = {16'h0000, imm16};
        r_known    = 1'b0;
        alu_result = '0;
        case (op)
            OP_RTYPE: begin
                r_known = 1'b1;
                case (func)
                    F_ADD:   alu_result = reg_a + reg_b;
                    F_SUB:   alu_result = reg_a - reg_b;
                    F_AND:   alu_result = reg_a & reg_b;
                    F_OR:    alu_result = reg_a | reg_b;
                    F_SLT:   alu_result = ($signed(reg_a) < $signed(reg_b)) ? 32'd1 : 32'd0;
                    F_SLL:   alu_result = reg_b << shamt;
                    default: r_known = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_result = reg_a + sext_imm;
            OP_ORI:                alu_result = reg_a | zext_imm;
            default:               alu_result = '0;
        endcase
    end

`ifdef MCPU_PERF_EN
    logic retire;
    assign retire = ((state == S_DECODE) && (op == OP_HALT)) ||
                    ((state == S_EXEC) && !is_mem && !is_alu) ||
                    ((state == S_MEM) && mem_ack && (op == OP_SW)) ||
                    (state == S_WB);
`endif

    // Main controller: state sequencing, architectural state and registered memory-port outputs
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            ir        <= '0;
            reg_a     <= '0;
            reg_b     <= '0;
            mdr       <= '0;
            for (int i = 0; i < 32; i++) regfile[i] <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
`ifdef MCPU_PERF_EN
            cycle_cnt   <= '0;
            instret_cnt <= '0;
`endif
        end else begin
`ifdef MCPU_PERF_EN
            if (state != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
            if (retire) instret_cnt <= instret_cnt + 32'd1;
`endif
            case (state)
                S_IDLE: begin
                    state     <= S_FETCH;
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b0;
                    mem_addr  <= pc;
                    mem_wdata <= '0;
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        ir       <= mem_rdata;
                        pc       <= pc_plus4;
                        mem_req  <= 1'b0;
                        mem_addr <= '0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    reg_a <= regfile[rs];
                    reg_b <= regfile[rt];
                    if (op == OP_HALT) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_mem) begin
                        state     <= S_MEM;
                        mem_req   <= 1'b1;
                        mem_we    <= (op == OP_SW);
                        mem_addr  <= mem_target;
                        mem_wdata <= reg_b;
                    end else if (is_alu) begin
                        state <= S_WB;
                    end else begin
                        state     <= S_FETCH;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        if (is_jump) begin
                            pc       <= jump_target;
                            mem_addr <= jump_target;
                        end else if (branch_taken) begin
                            pc       <= branch_target;
                            mem_addr <= branch_target;
                        end else begin
                            mem_addr <= pc;
                        end
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        if (op == OP_SW) begin
                            state    <= S_FETCH;
                            mem_req  <= 1'b1;
                            mem_addr <= pc;
                        end else begin
                            mdr      <= mem_rdata;
                            state    <= S_WB;
                            mem_req  <= 1'b0;
                            mem_addr <= '0;
                        end
                    end
                end
                S_WB: begin
                    if (dst != 5'd0) regfile[dst] <= wb_data;
                    state     <= S_FETCH;
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b0;
                    mem_addr  <= pc;
                    mem_wdata <= '0;
                end
                S_HALT: begin
                    mem_req <= 1'b0;
                    halted  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
